// File: rtl/frogger_game_seq_pkg.sv
// Shared game package: state encodings and parameter defaults for the game
// sequencer, display and score blocks.
package frogger_game_seq_pkg;

  localparam int c_DEF_LIVES           = 3;
  localparam int c_DEF_FRAMES_PER_SEC  = 60;
  localparam int c_DEF_TIME_LIMIT      = 30;
  localparam int c_DEF_DEATH_FRAMES    = 60;
  localparam int c_DEF_LEVELUP_FRAMES  = 90;
  localparam int c_DEF_GOALS_PER_LEVEL = 5;
  localparam int c_DEF_MAX_LEVEL       = 7;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PLAY      = 3'd1;
  localparam logic [2:0] ST_DYING     = 3'd2;
  localparam logic [2:0] ST_LEVEL_UP  = 3'd3;
  localparam logic [2:0] ST_GAME_OVER = 3'd4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frogger_game_seq_if.sv
// Signal bundle between the game sequencer and its environment: the
// master drives the game events, the slave (sequencer) reports game status.
interface frogger_game_seq_if;
  logic       i_Start;
  logic       i_Frame_Tick;
  logic       i_Collided;
  logic       i_Goal_Reached;
  logic [2:0] o_State;
  logic [1:0] o_Lives;
  logic [2:0] o_Level;
  logic [2:0] o_Goals;
  logic [5:0] o_Time_Left;
  logic       o_Move_Enable;
  logic       o_Frog_Reset;

  modport master (
    output i_Start, i_Frame_Tick, i_Collided, i_Goal_Reached,
    input  o_State, o_Lives, o_Level, o_Goals, o_Time_Left, o_Move_Enable, o_Frog_Reset
  );

  modport slave (
    input  i_Start, i_Frame_Tick, i_Collided, i_Goal_Reached,
    output o_State, o_Lives, o_Level, o_Goals, o_Time_Left, o_Move_Enable, o_Frog_Reset
  );
endinterface

// File: rtl/frame_pause_timer.sv
// Tick-driven pause down-counter shared by the death and level-up pauses:
// load a frame count, o_done flags the tick that exhausts it.
module frame_pause_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_tick,
  output logic         o_done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load)
      cnt_d = i_load_val;
    else if (i_tick && cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  // A count of 1 means the pending tick is the last one of the pause.
  assign o_done = i_tick && !i_load && (cnt_q <= W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/frogger_game_seq.sv
// Frogger game sequencer: lives, levels, goals, per-life countdown timer and
// the play / death / level-up / game-over flow. All outputs are registered.
module frogger_game_seq
  import frogger_game_seq_pkg::*;
#(
  parameter int c_LIVES           = c_DEF_LIVES,
  parameter int c_FRAMES_PER_SEC  = c_DEF_FRAMES_PER_SEC,
  parameter int c_TIME_LIMIT      = c_DEF_TIME_LIMIT,
  parameter int c_DEATH_FRAMES    = c_DEF_DEATH_FRAMES,
  parameter int c_LEVELUP_FRAMES  = c_DEF_LEVELUP_FRAMES,
  parameter int c_GOALS_PER_LEVEL = c_DEF_GOALS_PER_LEVEL,
  parameter int c_MAX_LEVEL       = c_DEF_MAX_LEVEL
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Start,
  input  logic       i_Frame_Tick,
  input  logic       i_Collided,
  input  logic       i_Goal_Reached,
  output logic [2:0] o_State,
  output logic [1:0] o_Lives,
  output logic [2:0] o_Level,
  output logic [2:0] o_Goals,
  output logic [5:0] o_Time_Left,
  output logic       o_Move_Enable,
  output logic       o_Frog_Reset
);

  localparam int FRAME_W = (c_FRAMES_PER_SEC > 1) ? $clog2(c_FRAMES_PER_SEC) : 1;
  localparam int PAUSE_W = $clog2(max_int(c_DEATH_FRAMES, c_LEVELUP_FRAMES) + 1);

  localparam logic [1:0]         LIVES_INIT = 2'(c_LIVES);
  localparam logic [5:0]         TIME_INIT  = 6'(c_TIME_LIMIT);
  localparam logic [2:0]         GOALS_LVL  = 3'(c_GOALS_PER_LEVEL);
  localparam logic [2:0]         LEVEL_MAX  = 3'(c_MAX_LEVEL);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(c_FRAMES_PER_SEC - 1);
  localparam logic [PAUSE_W-1:0] DEATH_LOAD = PAUSE_W'(c_DEATH_FRAMES);
  localparam logic [PAUSE_W-1:0] LVLUP_LOAD = PAUSE_W'(c_LEVELUP_FRAMES);

  logic [2:0]         state_q, state_d;
  logic               start_q;
  logic [1:0]         lives_q, lives_d;
  logic [2:0]         level_q, level_d;
  logic [2:0]         goals_q, goals_d;
  logic [5:0]         time_q, time_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               move_en_q, move_en_d;
  logic               frog_rst_q, frog_rst_d;

  logic               start_evt, sec_tick;
  logic [5:0]         time_nxt;
  logic [FRAME_W-1:0] frame_nxt;
  logic               pause_load, pause_tick, pause_done;
  logic [PAUSE_W-1:0] pause_val;

  assign pause_tick = i_Frame_Tick && (state_q == ST_DYING || state_q == ST_LEVEL_UP);

  frame_pause_timer #(.W(PAUSE_W)) u_pause (
    .clk        (i_Clk),
    .rst_n      (i_Rst_n),
    .i_load     (pause_load),
    .i_load_val (pause_val),
    .i_tick     (pause_tick),
    .o_done     (pause_done)
  );

  // Per-second countdown while playing; the remaining time never wraps below 0.
  always_comb begin
    start_evt = i_Start && !start_q;
    sec_tick  = i_Frame_Tick && (frame_q == FRAME_LAST);
    frame_nxt = !i_Frame_Tick ? frame_q : (sec_tick ? '0 : frame_q + FRAME_W'(1));
    time_nxt  = (sec_tick && time_q != '0) ? time_q - 6'd1 : time_q;
  end

  // NOTE: every _d takes its _q value first, so no path through the case infers a latch.
  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    level_d    = level_q;
    goals_d    = goals_q;
    time_d     = time_q;
    frame_d    = frame_q;
    frog_rst_d = 1'b0;
    pause_load = 1'b0;
    pause_val  = DEATH_LOAD;
    unique case (state_q)
      ST_IDLE: if (start_evt) begin
        state_d    = ST_PLAY;
        lives_d    = LIVES_INIT;
        level_d    = '0;
        goals_d    = '0;
        time_d     = TIME_INIT;
        frame_d    = '0;
        frog_rst_d = 1'b1;
      end
      ST_PLAY: begin
        time_d  = time_nxt;
        frame_d = frame_nxt;
        // Collision or timeout beats a goal arriving in the same cycle.
        if (i_Collided || time_nxt == '0) begin
          state_d    = ST_DYING;
          lives_d    = (lives_q != '0) ? lives_q - 2'd1 : '0;
          pause_load = 1'b1;
          pause_val  = DEATH_LOAD;
        end else if (i_Goal_Reached) begin
          goals_d    = goals_q + 3'd1;
          frog_rst_d = 1'b1;
          if (goals_q + 3'd1 == GOALS_LVL) begin
            state_d    = ST_LEVEL_UP;
            pause_load = 1'b1;
            pause_val  = LVLUP_LOAD;
          end else begin
            time_d  = TIME_INIT;
            frame_d = '0;
          end
        end
      end
      ST_DYING: if (pause_done) begin
        if (lives_q == '0) begin
          state_d = ST_GAME_OVER;
        end else begin
          state_d    = ST_PLAY;
          time_d     = TIME_INIT;
          frame_d    = '0;
          frog_rst_d = 1'b1;
        end
      end
      ST_LEVEL_UP: if (pause_done) begin
        state_d    = ST_PLAY;
        goals_d    = '0;
        level_d    = (level_q >= LEVEL_MAX) ? level_q : level_q + 3'd1;
        time_d     = TIME_INIT;
        frame_d    = '0;
        frog_rst_d = 1'b1;
      end
      ST_GAME_OVER: if (start_evt) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    move_en_d = (state_d == ST_PLAY);
  end

  // NOTE: non-blocking assignments so every flop samples the same pre-edge values.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      lives_q    <= '0;
      level_q    <= '0;
      goals_q    <= '0;
      time_q     <= '0;
      frame_q    <= '0;
      move_en_q  <= 1'b0;
      frog_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= i_Start;
      lives_q    <= lives_d;
      level_q    <= level_d;
      goals_q    <= goals_d;
      time_q     <= time_d;
      frame_q    <= frame_d;
      move_en_q  <= move_en_d;
      frog_rst_q <= frog_rst_d;
    end
  end

  assign o_State       = state_q;
  assign o_Lives       = lives_q;
  assign o_Level       = level_q;
  assign o_Goals       = goals_q;
  assign o_Time_Left   = time_q;
  assign o_Move_Enable = move_en_q;
  assign o_Frog_Reset  = frog_rst_q;

endmodule

// File: tb/tb_frogger_game_seq.sv
// Self-checking bench for frogger_game_seq: a behavioural game model queues
// the expected status for every applied input vector; a monitor compares.
`timescale 1ns/1ps
module tb_frogger_game_seq;

  localparam int LIVES = 3, FPS = 60, TLIM = 30, DEATH = 60, LVLUP = 90, GOALS = 5, MAXLVL = 7;
  localparam int S_IDLE = 0, S_PLAY = 1, S_DYING = 2, S_LVLUP = 3, S_OVER = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frogger_game_seq_if gif ();

  frogger_game_seq dut (
    .i_Clk          (clk),
    .i_Rst_n        (rst_n),
    .i_Start        (gif.i_Start),
    .i_Frame_Tick   (gif.i_Frame_Tick),
    .i_Collided     (gif.i_Collided),
    .i_Goal_Reached (gif.i_Goal_Reached),
    .o_State        (gif.o_State),
    .o_Lives        (gif.o_Lives),
    .o_Level        (gif.o_Level),
    .o_Goals        (gif.o_Goals),
    .o_Time_Left    (gif.o_Time_Left),
    .o_Move_Enable  (gif.o_Move_Enable),
    .o_Frog_Reset   (gif.o_Frog_Reset)
  );

  typedef struct packed {
    logic [2:0] state;
    logic [1:0] lives;
    logic [2:0] level;
    logic [2:0] goals;
    logic [5:0] time_left;
    logic       move_en;
    logic       frog_rst;
  } obs_t;

  typedef struct {
    int   due;
    obs_t exp;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Game model: whole-game quantities, pauses counted up in elapsed frames.
  int m_state, m_lives, m_level, m_goals, m_time, m_frames, m_pause, m_frog;
  bit m_start_prev;

  function automatic obs_t observe();
    obs_t o;
    o = {gif.o_State, gif.o_Lives, gif.o_Level, gif.o_Goals, gif.o_Time_Left,
         gif.o_Move_Enable, gif.o_Frog_Reset};
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.state     = 3'(m_state);
    o.lives     = 2'(m_lives);
    o.level     = 3'(m_level);
    o.goals     = 3'(m_goals);
    o.time_left = 6'(m_time);
    o.move_en   = (m_state == S_PLAY);
    o.frog_rst  = (m_frog != 0);
    return o;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_lives = 0; m_level = 0; m_goals = 0;
    m_time = 0; m_frames = 0; m_pause = 0; m_frog = 0; m_start_prev = 0;
  endtask

  task automatic model_step(input bit st, input bit tk, input bit col, input bit gl);
    bit start_ev;
    int t, f;
    start_ev = st && !m_start_prev;
    m_start_prev = st;
    m_frog = 0;
    case (m_state)
      S_IDLE: if (start_ev) begin
        m_state = S_PLAY; m_lives = LIVES; m_level = 0; m_goals = 0;
        m_time = TLIM; m_frames = 0; m_frog = 1;
      end
      S_PLAY: begin
        t = m_time; f = m_frames;
        if (tk) begin
          f++;
          if (f == FPS) begin
            f = 0;
            if (t > 0) t--;
          end
        end
        m_time = t; m_frames = f;
        if (col || t == 0) begin
          m_state = S_DYING; m_lives--; m_pause = 0;
        end else if (gl) begin
          m_goals++; m_frog = 1;
          if (m_goals == GOALS) begin
            m_state = S_LVLUP; m_pause = 0;
          end else begin
            m_time = TLIM; m_frames = 0;
          end
        end
      end
      S_DYING: if (tk) begin
        m_pause++;
        if (m_pause == DEATH) begin
          if (m_lives == 0) m_state = S_OVER;
          else begin
            m_state = S_PLAY; m_time = TLIM; m_frames = 0; m_frog = 1;
          end
        end
      end
      S_LVLUP: if (tk) begin
        m_pause++;
        if (m_pause == LVLUP) begin
          m_goals = 0;
          if (m_level < MAXLVL) m_level++;
          m_state = S_PLAY; m_time = TLIM; m_frames = 0; m_frog = 1;
        end
      end
      S_OVER: if (start_ev) m_state = S_IDLE;
      default: m_state = S_IDLE;
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One input vector per clock; the expected status is due one edge later.
  task automatic step(input bit st, input bit tk, input bit col, input bit gl);
    exp_t e;
    @(posedge clk);
    #1;
    gif.i_Start = st; gif.i_Frame_Tick = tk; gif.i_Collided = col; gif.i_Goal_Reached = gl;
    model_step(st, tk, col, gl);
    e.due = cyc + 1;
    e.exp = model_obs();
    sb_q.push_back(e);
  endtask

  // Idle inputs, let the scoreboard drain, then leave time for direct checks.
  task automatic checkpoint();
    step(0, 0, 0, 0);
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: %0d expected vectors never compared", sb_q.size());
      sb_q.delete();
    end
    #1;
  endtask

  task automatic start_edge();
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) step(0, 1, 0, 0);
  endtask

  task automatic do_reset(input string tag);
    gif.i_Start = 0; gif.i_Frame_Tick = 0; gif.i_Collided = 0; gif.i_Goal_Reached = 0;
    rst_n = 1'b0;
    #1;
    check({tag, "_state"},    gif.o_State, 0);
    check({tag, "_lives"},    gif.o_Lives, 0);
    check({tag, "_level"},    gif.o_Level, 0);
    check({tag, "_goals"},    gif.o_Goals, 0);
    check({tag, "_time"},     gif.o_Time_Left, 0);
    check({tag, "_move_en"},  gif.o_Move_Enable, 0);
    check({tag, "_frog_rst"}, gif.o_Frog_Reset, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares every queued expectation on the falling edge it is due.
  initial begin
    exp_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        a = observe();
        n_vec++;
        if (a !== e.exp) begin
          n_err++;
          $display("FAIL scoreboard cyc=%0d: got st=%0d lives=%0d lvl=%0d goals=%0d time=%0d mv=%0d fr=%0d, expected st=%0d lives=%0d lvl=%0d goals=%0d time=%0d mv=%0d fr=%0d",
                   cyc, a.state, a.lives, a.level, a.goals, a.time_left, a.move_en, a.frog_rst,
                   e.exp.state, e.exp.lives, e.exp.level, e.exp.goals, e.exp.time_left,
                   e.exp.move_en, e.exp.frog_rst);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    do_reset("reset");
    repeat (3) step(0, 0, 0, 0);

    // Start edge: play, full lives, full time, one frog reset pulse
    start_edge();
    checkpoint();
    check("start_state", gif.o_State, S_PLAY);
    check("start_lives", gif.o_Lives, LIVES);
    check("start_time", gif.o_Time_Left, TLIM);
    check("start_move", gif.o_Move_Enable, 1);

    // One second of frames, then run out the clock
    ticks(FPS);
    checkpoint();
    check("one_second_time", gif.o_Time_Left, TLIM - 1);
    ticks(FPS * TLIM - FPS);
    checkpoint();
    check("timeout_state", gif.o_State, S_DYING);
    check("timeout_lives", gif.o_Lives, LIVES - 1);
    ticks(DEATH);
    checkpoint();
    check("death_return", gif.o_State, S_PLAY);

    // Eight level-ups: level climbs to the ceiling and stays there
    for (int lv = 1; lv <= MAXLVL + 1; lv++) begin
      for (int g = 0; g < GOALS; g++) begin
        step(0, 0, 0, 1);
        step(0, $urandom_range(0, 1) == 1, 0, 0);
      end
      checkpoint();
      check("levelup_state", gif.o_State, S_LVLUP);
      ticks(LVLUP);
      checkpoint();
      check("levelup_level", gif.o_Level, (lv > MAXLVL) ? MAXLVL : lv);
      check("levelup_goals", gif.o_Goals, 0);
    end

    // Collision and goal together: collision wins, goal discarded
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    checkpoint();
    check("colgoal_state", gif.o_State, S_DYING);
    check("colgoal_goals", gif.o_Goals, 1);
    check("colgoal_lives", gif.o_Lives, LIVES - 2);
    ticks(DEATH);
    step(0, 0, 1, 0);
    ticks(DEATH);
    checkpoint();
    check("game_over_state", gif.o_State, S_OVER);
    check("game_over_lives", gif.o_Lives, 0);
    check("game_over_level", gif.o_Level, MAXLVL);

    // Two start edges: back to idle, then a fresh game; three deaths end it
    start_edge();
    checkpoint();
    check("over_to_idle", gif.o_State, S_IDLE);
    start_edge();
    checkpoint();
    check("new_game_lives", gif.o_Lives, LIVES);
    repeat (LIVES) begin
      step(0, 0, 1, 0);
      ticks(DEATH);
    end
    checkpoint();
    check("three_deaths_state", gif.o_State, S_OVER);
    start_edge();
    start_edge();
    checkpoint();
    check("restart_state", gif.o_State, S_PLAY);

    // Random play against the model
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0);
    checkpoint();

    // Reset in the middle of a death pause
    do_reset("reset_rand");
    start_edge();
    step(0, 0, 1, 0);
    ticks(10);
    checkpoint();
    check("mid_dying_state", gif.o_State, S_DYING);
    do_reset("reset_dying");
    repeat (6) step(0, 0, 0, 0);
    start_edge();
    checkpoint();
    check("after_reset_start", gif.o_State, S_PLAY);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
